// File: rtl/eprisc_io_arbiter.sv
// Two-master arbiter in front of a single 4-register peripheral bus (round-robin or fixed priority).
// Latency: request sampled in IDLE -> ack after WAIT_STATES+2 cycles; one transaction per WAIT_STATES+3 cycles.
// Backpressure: masters hold req until ack; requests are ignored outside IDLE, so the loser simply waits.
module eprisc_io_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          FAIR        = 1'b1
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iM0Req,
    input  logic        iM1Req,
    input  logic        iM0Write,
    input  logic        iM1Write,
    input  logic [1:0]  iM0Address,
    input  logic [1:0]  iM1Address,
    input  logic [15:0] iM0Data,
    input  logic [15:0] iM1Data,
    output logic        oM0Ack,
    output logic        oM1Ack,
    output logic [15:0] oM0Data,
    output logic [15:0] oM1Data,
    output logic [1:0]  oAddress,
    output logic [15:0] oData,
    input  logic [15:0] iData,
    output logic        oWrite,
    output logic        oEnable,
    output logic        oBusy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Index of the final ACCESS cycle; the enable is held for CNT_LAST+1 cycles.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic        gnt_q, gnt_d;    // 0 = M0, 1 = M1 owns the current transaction
    logic        last_q, last_d;  // master granted most recently; resets to M1 so M0 wins first
    logic        win;

    // Winner selection: a lone request always wins; a conflict goes to the
    // master not granted last (FAIR) or to M0 (fixed priority).
    always_comb begin
        win = 1'b0;
        if (iM0Req && iM1Req) begin
            win = FAIR ? ~last_q : 1'b0;
        end else begin
            win = iM1Req;
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> DONE sequence and its datapath latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (iM0Req || iM1Req) begin
                    gnt_d   = win;
                    last_d  = win;
                    wr_d    = win ? iM1Write   : iM0Write;
                    addr_d  = win ? iM1Address : iM0Address;
                    wdat_d  = win ? iM1Data    : iM0Data;
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Peripheral read data is captured only on the last enable cycle.
                    if (!wr_q) begin
                        rdat_d = iData;
                    end
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 2'd0;
            wdat_q  <= 16'd0;
            rdat_q  <= 16'd0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Peripheral strobes are gated by ACCESS so the bus is all-zero at any other time.
    always_comb begin
        oEnable  = (state_q == ST_ACCESS);
        oWrite   = oEnable ? wr_q   : 1'b0;
        oAddress = oEnable ? addr_q : 2'd0;
        oData    = oEnable ? wdat_q : 16'd0;
        oBusy    = (state_q != ST_IDLE);
        oM0Ack   = (state_q == ST_DONE) && !gnt_q;
        oM1Ack   = (state_q == ST_DONE) &&  gnt_q;
        oM0Data  = gnt_q ? 16'd0  : rdat_q;
        oM1Data  = gnt_q ? rdat_q : 16'd0;
    end

endmodule

// File: doc/eprisc_io_arbiter.md
EPRISC_IO_ARBITER -- requirements
Module: eprisc_io_arbiter

Interface
REQ-001 The module SHALL have parameter WAIT_STATES, default 1: the number of extra cycles the peripheral enable is held beyond the first (range 0-15).
REQ-002 The module SHALL have parameter FAIR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with M0 highest.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 iClock  input  1  sole clock; all state changes on its rising edge.
REQ-005 iReset_n  input  1  asynchronous active-low reset.
REQ-006 iM0Req, iM1Req  input  1 each  master request; held high until that master's ack.
REQ-007 iM0Write, iM1Write  input  1 each  1 = write, 0 = read; stable while request is high.
REQ-008 iM0Address, iM1Address  input  2 each  peripheral register index.
REQ-009 iM0Data, iM1Data  input  16 each  write data.
REQ-010 oM0Ack, oM1Ack  output  1 each  single-cycle completion pulse.
REQ-011 oM0Data, oM1Data  output  16 each  read data, valid while the matching ack is high.
REQ-012 oAddress  output  2  peripheral register index.
REQ-013 oData  output  16  write data to the peripheral.
REQ-014 iData  input  16  read data from the peripheral; combinational from oAddress, oWrite and oEnable.
REQ-015 oWrite, oEnable  output  1 each  peripheral strobes.
REQ-016 oBusy  output  1  high in ACCESS and DONE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 IDLE, any request high: select a winner; latch its write flag, address and data; latch the winner's id; go to ACCESS.
REQ-019 IDLE, no request: remain in IDLE.
REQ-020 With FAIR=1, simultaneous requests SHALL grant the master not granted last; a lone request is granted regardless of history.
REQ-021 With FAIR=0, M0 SHALL win every conflict.
REQ-022 The last-granted pointer SHALL update only on grant and SHALL reset to M1, so M0 wins the first conflict.
REQ-023 ACCESS SHALL drive oEnable=1 and oAddress, oData and oWrite from the latched values for exactly WAIT_STATES+1 consecutive cycles, counted by a 4-bit counter.
REQ-024 On the final ACCESS cycle of a read, iData SHALL be registered into the read-data register; then go to DONE.
REQ-025 A write completes from ACCESS to DONE with the read-data register unchanged.
REQ-026 In DONE, oEnable=0 and the granted master's ack is high for exactly one cycle; the other ack stays 0; then go to IDLE.
REQ-027 oMxData SHALL equal the read-data register for the granted master, and 0 otherwise.
REQ-028 Latency from a request sampled in IDLE to ack SHALL be WAIT_STATES+2 cycles; back-to-back throughput SHALL be one transaction per WAIT_STATES+3 cycles.
REQ-029 A master SHALL drop its request in the cycle after its ack; a request still high in IDLE is a new transaction.
REQ-030 Outside ACCESS, oAddress, oData, oWrite and oEnable SHALL all be 0, so no spurious peripheral access occurs.
REQ-031 Request inputs SHALL be ignored outside IDLE.
REQ-032 A master dropping its request mid-transaction does not abort it; the ack still issues.
REQ-033 A request that drops before it is sampled in IDLE is never granted.

Reset
REQ-034 Asserting iReset_n low SHALL immediately force: state IDLE, all outputs 0, counter 0, read-data register 0, last-granted pointer M1.
REQ-035 Reset in ACCESS or DONE SHALL abort the transaction with no ack after release.
REQ-036 The first request sampled after release SHALL be arbitrated normally.

Verification
REQ-037 WAIT_STATES=1: M0 writes 0x00FF to address 0 -> oEnable high 2 cycles with oAddress=0, oData=0x00FF, oWrite=1; oM0Ack at cycle 3.
REQ-038 M1 reads address 2 while iData=0xA5C3 -> oM1Ack pulse with oM1Data=0xA5C3; oM0Ack stays 0.
REQ-039 FAIR=1, both masters request continuously for 4 transactions -> grants alternate M0, M1, M0, M1.
REQ-040 FAIR=0, both masters request continuously -> M0 granted every transaction while M1 waits.
REQ-041 iReset_n low during ACCESS of M0's write -> oEnable=0 at once, no ack; the next request is served normally after release.
REQ-042 WAIT_STATES=0: single read -> oEnable high 1 cycle; ack 2 cycles after the request.
